// File: rtl/deserializer_sipo.sv
`default_nettype none
// ============================================================================
// Module : deserializer_sipo
// Brief  : Serial-in/parallel-out receive stage. Frames are start bit, LSB-first
//          data, optional even parity, and stop bit. Words leave on valid/ready.
// Rev    : 1.0  initial release
// ============================================================================
module deserializer_sipo #(
    parameter int DATA_WIDTH = 8,
    parameter int PARITY_EN  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bit_en,
    input  logic                  srl_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid,
    input  logic                  ready,
    output logic                  frame_err,
    output logic                  parity_err,
    output logic                  overrun
);

    localparam int c_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DATA   = 3'd1,
        S_PARITY = 3'd2,
        S_STOP   = 3'd3,
        S_RESYNC = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [c_CNT_W-1:0]      r_cnt;
    logic [c_CNT_W-1:0]      w_cnt_nxt;
    logic [DATA_WIDTH-1:0]   r_shreg;
    logic [DATA_WIDTH-1:0]   w_shreg_nxt;
    logic                    r_perr;
    logic                    w_perr_nxt;
    logic                    w_good;
    logic                    w_ferr;
    logic                    w_pfail;

    logic [DATA_WIDTH-1:0]   r_data;
    logic                    r_valid;
    logic                    r_frame_err;
    logic                    r_parity_err;
    logic                    r_overrun;

    // Next-state and frame-completion decode; everything advances only on bit_en.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shreg_nxt = r_shreg;
        w_perr_nxt  = r_perr;
        w_good      = 1'b0;
        w_ferr      = 1'b0;
        w_pfail     = 1'b0;
        if (bit_en) begin
            case (r_state)
                S_IDLE: begin
                    if (!srl_in) begin
                        w_state_nxt = S_DATA;
                        w_cnt_nxt   = '0;
                        w_perr_nxt  = 1'b0;
                    end
                end
                S_DATA: begin
                    w_shreg_nxt = {srl_in, r_shreg[DATA_WIDTH-1:1]};
                    w_cnt_nxt   = r_cnt + 1'b1;
                    if (r_cnt == c_CNT_LAST) begin
                        w_state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end
                end
                S_PARITY: begin
                    w_perr_nxt  = (^r_shreg) ^ srl_in;
                    w_state_nxt = S_STOP;
                end
                S_STOP: begin
                    // A bad stop bit outranks a parity mismatch.
                    if (!srl_in) begin
                        w_ferr      = 1'b1;
                        w_state_nxt = S_RESYNC;
                    end else begin
                        if ((PARITY_EN != 0) && r_perr) begin
                            w_pfail = 1'b1;
                        end else begin
                            w_good = 1'b1;
                        end
                        w_state_nxt = S_IDLE;
                    end
                end
                S_RESYNC: begin
                    if (srl_in) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_shreg      <= '0;
            r_perr       <= 1'b0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_shreg      <= w_shreg_nxt;
            r_perr       <= w_perr_nxt;
            r_frame_err  <= w_ferr;
            r_parity_err <= w_pfail;
            r_overrun    <= w_good && r_valid && !ready;
            // A good frame may load in the same cycle the held word transfers.
            if (w_good && (!r_valid || ready)) begin
                r_data  <= r_shreg;
                r_valid <= 1'b1;
            end else if (r_valid && ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data_out   = r_data;
    assign valid      = r_valid;
    assign frame_err  = r_frame_err;
    assign parity_err = r_parity_err;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: doc/deserializer_sipo.md
# deserializer_sipo

Serial-input, parallel-output (SIPO) receive stage for the transceiver path: it consumes the serial bitstream produced by the PISO serializer, one bit per `bit_en` strobe. It detects framing (start bit, data bits LSB-first, optional even parity, stop bit) and assembles each frame into a DATA_WIDTH-bit word. Words are presented on a valid/ready output interface, and framing, parity and overrun conditions are flagged.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame, must be ≥ 2.
- `PARITY_EN`, default 0: 1 inserts an even-parity bit between the last data bit and the stop bit.

- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `bit_en`  in  1  one-cycle bit-time strobe; `srl_in` is sampled only on cycles with `bit_en`=1; may be high every cycle.
- `srl_in`  in  1  serial data, idle high; same clock domain as `clk`.
- `data_out`  out  DATA_WIDTH  received word; stable while `valid`=1.
- `valid`  out  1  `data_out` holds an untransferred word.
- `ready`  in  1  downstream accepts; transfer happens on any cycle with `valid`&`ready`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled as 0.
- `parity_err`  out  1  one-cycle pulse: parity mismatch (PARITY_EN=1 only, otherwise constant 0).
- `overrun`  out  1  one-cycle pulse: a good frame was dropped because the output was occupied.

## Operation
- Frame format: start bit (0), DATA_WIDTH data bits LSB-first, optional parity bit, stop bit (1).
- States: IDLE, DATA, PARITY, STOP, RESYNC. Transitions occur only on `bit_en`=1 cycles; when `bit_en`=0 the state holds.
- **IDLE**: `srl_in`=0 → DATA, bit counter cleared to 0. `srl_in`=1 → stay in IDLE.
- **DATA**:
  - Shift register updates as shreg ← {srl_in, shreg[W-1:1]}, and the counter increments.
  - When the counter reaches W-1 (the W-th bit is sampled), go to PARITY if PARITY_EN=1, else STOP.
  - The counter width is clog2(DATA_WIDTH).
- **PARITY**: capture the parity bit; perr = ^shreg ^ srl_in (nonzero = error) → STOP.
- **STOP**:
  - `srl_in`=1 and no parity error → good frame → IDLE.
  - `srl_in`=1 with a parity error → `parity_err` pulse, word discarded → IDLE.
  - `srl_in`=0 → `frame_err` pulse, word discarded → RESYNC. This check takes priority: when both errors occur, only `frame_err` pulses.
- **RESYNC**: wait for a sample with `srl_in`=1 → IDLE. A held-low line (break) is never taken as a start bit.
- Good frame handling:
  - If `valid`=0, or `valid`&`ready` in the same cycle: `data_out` ← shreg and `valid` ← 1.
  - Otherwise: the existing word is kept, the new word is dropped, and `overrun` pulses.
- Output register: `valid` clears the cycle after a transfer, unless a good frame loads in that same transfer cycle, in which case `valid` stays 1 with the new data.
- Back-to-back frames: a start bit on the strobe immediately after the stop strobe is accepted.
- Reset mid-frame: the frame is aborted, state returns to IDLE, and no word or error is reported.

## Timing
- Reset values: `data_out`=0, `valid`=0, `frame_err`=0, `parity_err`=0, `overrun`=0; state IDLE, shreg=0, counter=0.
- Latency: if the stop bit is sampled on the edge at the end of cycle N, then `valid`/`data_out` (or the error/overrun pulse) appear in cycle N+1.
- Error and overrun pulses are registered and last exactly one cycle, independent of `bit_en`.
- Minimum frame length: 2 + DATA_WIDTH + PARITY_EN strobes. With `bit_en`=1 continuously, sustained throughput is one word per 10 cycles (W=8, no parity).
- `data_out` changes only on a load. No combinational path exists from `ready` to `valid`.

## Test plan
- Reset with `srl_in`=1 and `bit_en` toggling → all outputs 0; no `valid` for 20 cycles.
- W=8, `bit_en` every 4th cycle, `ready`=1, frame 0xA5 (serial bits 0,1,0,1,0,0,1,0,1,1) → `valid`=1 for exactly 1 cycle with `data_out`=0xA5, starting 1 cycle after the stop strobe.
- `bit_en`=1 continuously, `ready`=0, frames 0x3C then 0xC3 back-to-back → `data_out`=0x3C held; `overrun` pulses once after the second stop. Then raise `ready` → one transfer of 0x3C, then `valid`=0.
- Stop bit 0 on frame 0x12 → `frame_err` pulse, no `valid`. Hold line 0 for 6 strobes → no start detected. Then line 1, then frame 0x55 → `data_out`=0x55.
- PARITY_EN=1:
  - Frame 0x07 with parity bit 1 → `valid` with 0x07.
  - Frame 0x07 with parity bit 0 → `parity_err` pulse, no `valid`.
- `rst` asserted for 1 cycle after data bit 4 of a frame, then frame 0x81 sent → only 0x81 is ever output.
- Simultaneous events: `valid`=1 with 0x11 and `ready`=1 in the same cycle a good frame 0x22 loads → `valid` stays 1, `data_out`=0x22, no `overrun`.
